lcg_seed_search: RTL
====================

# lcg_seed_search

Parametrised multi-lane LCG seed recovery engine, the next generation of the single-lane seed scanner. It scans a programmable seed range, testing LANES consecutive seeds per clock through a DEPTH-stage pipeline. Each stage performs one LCG step, and each lane's output sequence is compared against DEPTH expected values. A start/busy/done handshake lets a host or top-level FSM launch repeated searches without reconfiguring the FPGA.

## Interface
- WIDTH, 32: bit width of seeds, LCG state and constants.
- LANES, 4: seeds tested per clock; must be ≥1.
- DEPTH, 3: consecutive LCG outputs compared; also pipeline stages; must be ≥1.
- CLK  in  1  system clock (16 MHz on board).
- RST_N  in  1  reset; synchronous, active-low.
- start  in  1  launch pulse; accepted only when busy=0.
- modulus, multiplier, increment  in  WIDTH each  m, a, c.
- seed_lo, seed_hi  in  WIDTH each  inclusive scan range.
- expected  in  DEPTH*WIDTH  expected outputs; bits [WIDTH-1:0] = v0, next slice = v1, and so on.
- busy  out  1  search in progress.
- found  out  1  matching seed located (sticky until next start or reset).
- exhausted  out  1  range finished without a match (sticky).
- valid_seed  out  WIDTH  matching seed; meaningful only when found=1.
- match_count  out  WIDTH  present only with LCG_SEARCH_ALL_EN.

## Operation
- States:
  - IDLE to SCAN on accepted start.
  - SCAN to DRAIN when the last batch has been issued.
  - SCAN or DRAIN to DONE on match or when the pipeline is empty.
  - DONE to SCAN on start.
- On start: latch m, a, c, seed_lo, seed_hi, expected, and clear found, exhausted, match_count. Later input changes are ignored until the next start.
- Issue: batch k carries seeds seed_lo + k*LANES + i for i = 0..LANES-1.
  - The base counter is WIDTH+1 bits wide, so seed_hi = 2^WIDTH-1 terminates without wrap.
  - Lanes with seed > seed_hi are invalid and never match.
- Stage j, for each lane: v_j = (a*v_{j-1} + c) mod m, with v_{-1} = seed.
  - Product and sum are computed at 2*WIDTH+1 bits; the remainder is truncated to WIDTH.
  - A valid bit travels with each lane.
- Compare: a lane matches when all DEPTH outputs equal expected. With several matching lanes in one batch, the lowest lane index wins.
- First match (default build):
  - Set found=1 and valid_seed.
  - Discard all in-flight batches.
  - Enter DONE with busy=0.
- Degenerate inputs: modulus=0, or seed_lo > seed_hi, goes straight to DONE with exhausted=1, one cycle after start.
- Reset (any state, including mid-scan): IDLE, busy=0, found=0, exhausted=0, valid_seed=0, match_count=0, all pipeline valid bits cleared.
- start while busy=1 is ignored.

## Timing
- Edge numbering: start is sampled on edge 0, batch k enters stage 1 on edge k+1, and its compare result is registered on edge k+DEPTH+1.
- busy rises on edge 0 and falls on the same edge that sets found or exhausted.
- found/valid_seed for batch k update on edge k+DEPTH+1.
- exhausted sets on edge K+DEPTH+1, where K is the last batch index: K = ceil((seed_hi-seed_lo+1)/LANES) - 1.
- Throughput: LANES seeds per cycle with no bubbles. A restart from DONE is accepted on the cycle after busy falls.

## Configuration
- LCG_SEARCH_ALL_EN defined:
  - Scanning continues after a match until the range is exhausted.
  - found sets on the first match; valid_seed holds the highest matching seed.
  - match_count increments by the number of matching lanes in each batch and saturates at 2^WIDTH-1.
  - exhausted sets at the end regardless of matches.
- Undefined: stop at first match; the match_count port is absent.

## Test plan
- Known seed: m=993441, a=4001, c=60211, expected 444307/466569/127141, range 0..1000, default params. Required: found=1, valid_seed=96 after edge 28, busy=0, exhausted=0.
- No match: same constants, range 97..200. Required: exhausted=1 after edge 29, found=0.
- Lane priority: m=10, a=0, c=3, expected 3/3/3, range 6..9. Required: valid_seed=6 after edge 4.
- Range edge: range 2^32-3..2^32-1 with a=0, c=3, m=10, expected 3/3/3, and LCG_SEARCH_ALL_EN. Required: exactly 3 matches counted, valid_seed=2^32-1, no wrap to seed 0.
- Reset mid-scan: assert RST_N=0 on edge 10 of the known-seed case. Required: all outputs 0 next cycle. A fresh start then reproduces valid_seed=96 at edge 28.
- Degenerate: modulus=0. Required: exhausted=1 and busy=0 after edge 1. A start during busy is ignored.

Source files
------------

// File: rtl/lcg_seed_search.sv
// Multi-lane LCG seed recovery: LANES seeds per clock through a DEPTH-stage LCG pipeline.
// Define LCG_SEARCH_ALL_EN to keep scanning after a match and count every match.
module lcg_seed_search #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 3
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    input  logic [WIDTH-1:0]       modulus,
    input  logic [WIDTH-1:0]       multiplier,
    input  logic [WIDTH-1:0]       increment,
    input  logic [WIDTH-1:0]       seed_lo,
    input  logic [WIDTH-1:0]       seed_hi,
    input  logic [DEPTH*WIDTH-1:0] expected,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [WIDTH-1:0]       valid_seed
`ifdef LCG_SEARCH_ALL_EN
    ,
    output logic [WIDTH-1:0]       match_count
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]       m_q, m_d, a_q, a_d, c_q, c_d, hi_q, hi_d;
    logic [DEPTH*WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH:0]         base_q, base_d;
    logic                   found_q, found_d, exh_q, exh_d;
    logic [WIDTH-1:0]       seed_q, seed_d;
`ifdef LCG_SEARCH_ALL_EN
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH:0]         pc, sum;
    logic [WIDTH-1:0]       hi_idx;
`else
    logic [WIDTH-1:0]       lo_idx;
`endif

    // Each stage carries its LCG state per lane plus a running "all equal so far" bit.
    logic [WIDTH-1:0] val_q [DEPTH][LANES];
    logic [WIDTH-1:0] val_d [DEPTH][LANES];
    logic [LANES-1:0] ok_q [DEPTH];
    logic [LANES-1:0] ok_d [DEPTH];
    logic [WIDTH-1:0] bs_q [DEPTH];
    logic [WIDTH-1:0] bs_d [DEPTH];
    logic [DEPTH-1:0] bv_q, bv_d, last_q, last_d;

    logic             degen, issue, hit;
    logic [WIDTH:0]   sw;
    logic [WIDTH-1:0] v;

    function automatic logic [WIDTH-1:0] lcg_step(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] m
    );
        logic [2*WIDTH:0] p;
        logic [2*WIDTH:0] r;
        p = {{(WIDTH+1){1'b0}}, a} * {{(WIDTH+1){1'b0}}, x}
            + {{(WIDTH+1){1'b0}}, c};
        r = p % {{(WIDTH+1){1'b0}}, m};
        return r[WIDTH-1:0];
    endfunction

    assign busy       = (state_q == SCAN) || (state_q == DRAIN);
    assign found      = found_q;
    assign exhausted  = exh_q;
    assign valid_seed = seed_q;
`ifdef LCG_SEARCH_ALL_EN
    assign match_count = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        m_d     = m_q;
        a_d     = a_q;
        c_d     = c_q;
        hi_d    = hi_q;
        exp_d   = exp_q;
        found_d = found_q;
        exh_d   = exh_q;
        seed_d  = seed_q;
        sw      = '0;
        v       = '0;
`ifdef LCG_SEARCH_ALL_EN
        cnt_d   = cnt_q;
        pc      = '0;
        sum     = '0;
        hi_idx  = '0;
`else
        lo_idx  = '0;
`endif
        degen = (m_q == '0) || (base_q > {1'b0, hi_q});
        issue = (state_q == SCAN) && !degen;

        bv_d[0]   = issue;
        bs_d[0]   = base_q[WIDTH-1:0];
        last_d[0] = issue &&
                    (base_q + (WIDTH+1)'(LANES-1) >= {1'b0, hi_q});
        for (int i = 0; i < LANES; i++) begin
            sw = base_q + (WIDTH+1)'(i);
            v  = lcg_step(sw[WIDTH-1:0], a_q, c_q, m_q);
            val_d[0][i] = v;
            ok_d[0][i]  = issue && (sw <= {1'b0, hi_q}) &&
                          (v == exp_q[0 +: WIDTH]);
        end
        for (int j = 1; j < DEPTH; j++) begin
            bv_d[j]   = bv_q[j-1];
            last_d[j] = last_q[j-1];
            bs_d[j]   = bs_q[j-1];
            for (int i = 0; i < LANES; i++) begin
                v = lcg_step(val_q[j-1][i], a_q, c_q, m_q);
                val_d[j][i] = v;
                ok_d[j][i]  = ok_q[j-1][i] &&
                              (v == exp_q[j*WIDTH +: WIDTH]);
            end
        end

        hit = |ok_q[DEPTH-1];
`ifdef LCG_SEARCH_ALL_EN
        for (int i = 0; i < LANES; i++) begin
            if (ok_q[DEPTH-1][i]) hi_idx = WIDTH'(i);
            pc = pc + {{WIDTH{1'b0}}, ok_q[DEPTH-1][i]};
        end
        sum = {1'b0, cnt_q} + pc;
`else
        for (int i = LANES - 1; i >= 0; i--) begin
            if (ok_q[DEPTH-1][i]) lo_idx = WIDTH'(i);
        end
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SCAN;
                    base_d  = {1'b0, seed_lo};
                    m_d     = modulus;
                    a_d     = multiplier;
                    c_d     = increment;
                    hi_d    = seed_hi;
                    exp_d   = expected;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    seed_d  = '0;
`ifdef LCG_SEARCH_ALL_EN
                    cnt_d   = '0;
`endif
                end
            end
            SCAN: begin
                if (degen) begin
                    state_d = DONE;
                    exh_d   = 1'b1;
                end else begin
                    base_d = base_q + (WIDTH+1)'(LANES);
                    if (last_d[0]) state_d = DRAIN;
                end
            end
            default: ;
        endcase

        if (busy && bv_q[DEPTH-1]) begin
`ifdef LCG_SEARCH_ALL_EN
            if (hit) begin
                found_d = 1'b1;
                seed_d  = bs_q[DEPTH-1] + hi_idx;
                cnt_d   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            end
            if (last_q[DEPTH-1]) begin
                exh_d   = 1'b1;
                state_d = DONE;
            end
`else
            if (hit) begin
                found_d = 1'b1;
                seed_d  = bs_q[DEPTH-1] + lo_idx;
                state_d = DONE;
            end else if (last_q[DEPTH-1]) begin
                exh_d   = 1'b1;
                state_d = DONE;
            end
`endif
        end

        // Leaving the scan drops whatever batches are still in flight.
        if (state_d == DONE) begin
            bv_d   = '0;
            last_d = '0;
            for (int j = 0; j < DEPTH; j++) ok_d[j] = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            base_q  <= '0;
            m_q     <= '0;
            a_q     <= '0;
            c_q     <= '0;
            hi_q    <= '0;
            exp_q   <= '0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            seed_q  <= '0;
`ifdef LCG_SEARCH_ALL_EN
            cnt_q   <= '0;
`endif
            bv_q    <= '0;
            last_q  <= '0;
            for (int j = 0; j < DEPTH; j++) ok_q[j] <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            m_q     <= m_d;
            a_q     <= a_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            exp_q   <= exp_d;
            found_q <= found_d;
            exh_q   <= exh_d;
            seed_q  <= seed_d;
`ifdef LCG_SEARCH_ALL_EN
            cnt_q   <= cnt_d;
`endif
            bv_q    <= bv_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
        end
    end

    always_ff @(posedge CLK) begin
        val_q <= val_d;
        bs_q  <= bs_d;
    end

endmodule
